lsu_req_queue: RTL and testbench

Request queue directly upstream of the store unit and load unit inside the LSU. Issue-stage requests (`lsu_ctrl_t`) are captured into a small circular FIFO. The head entry is presented to both consumer units, and the head is retired when either unit pops it (`pop_st`/`pop_ld`). The queue decouples issue from address translation and store-buffer back-pressure, and is discarded on pipeline flush.

---
 rtl/lsu_req_queue_if.sv | 58 +++++
 rtl/lsu_req_queue.sv | 115 +++++++++++
 tb/tb_lsu_req_queue.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_req_queue_if.sv
// Request-queue types and the issue/consumer handshake bundle for lsu_req_queue.
// The queue sits on the slave modport; issue and the load/store units drive the master side.

package lsu_req_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [31:0] vaddr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [3:0]  operation;
        logic [2:0]  trans_id;
    } lsu_ctrl_t;

endpackage

interface lsu_req_queue_if #(
    parameter int DEPTH = 2
);
    import lsu_req_queue_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic          flush_i;
    logic          lsu_req_valid_i;
    lsu_ctrl_t     lsu_req_i;
    logic          ready_o;
    logic          pop_ld_i;
    logic          pop_st_i;
    lsu_ctrl_t     lsu_ctrl_o;
    logic          empty_o;
    logic [CW-1:0] count_o;

    modport slave (
        input  flush_i,
        input  lsu_req_valid_i,
        input  lsu_req_i,
        input  pop_ld_i,
        input  pop_st_i,
        output ready_o,
        output lsu_ctrl_o,
        output empty_o,
        output count_o
    );

    modport master (
        output flush_i,
        output lsu_req_valid_i,
        output lsu_req_i,
        output pop_ld_i,
        output pop_st_i,
        input  ready_o,
        input  lsu_ctrl_o,
        input  empty_o,
        input  count_o
    );

endinterface

// File: rtl/lsu_req_queue.sv
// Circular request FIFO between issue and the LSU load/store units (DEPTH >= 2, power of two).
// Optional zero-latency forwarding of requests into an empty queue: define LSU_REQ_QUEUE_BYPASS_EN.

module lsu_req_queue
    import lsu_req_queue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    lsu_req_queue_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    lsu_ctrl_t       mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    logic            stored_valid;
    logic            ready;
    logic            pop_req;
    logic            fwd_pop;
    logic            push;
    logic            pop;
    lsu_ctrl_t       head;

    assign stored_valid = (count_q != '0);
    assign ready        = (count_q < DEPTH_C);
    assign pop_req      = bus.pop_ld_i | bus.pop_st_i;

    // Stored entries always take precedence; forwarding only ever fills an empty queue.
    always_comb begin
        head = '0;
        if (stored_valid) begin
            head       = mem_q[rd_ptr_q];
            head.valid = 1'b1;
        end
`ifdef LSU_REQ_QUEUE_BYPASS_EN
        else if (bus.lsu_req_valid_i && !bus.flush_i) begin
            head       = bus.lsu_req_i;
            head.valid = 1'b1;
        end
`endif
    end

`ifdef LSU_REQ_QUEUE_BYPASS_EN
    assign fwd_pop = ~stored_valid & head.valid & pop_req & ~bus.flush_i;
`else
    assign fwd_pop = 1'b0;
`endif

    // A forwarded request consumed in the same cycle never touches storage.
    assign push = bus.lsu_req_valid_i & ready & ~bus.flush_i & ~fwd_pop;
    assign pop  = pop_req & stored_valid & ~bus.flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (bus.flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= bus.lsu_req_i;
        end
    end

    assign bus.ready_o    = ready;
    assign bus.lsu_ctrl_o = head;
    assign bus.empty_o    = ~stored_valid;
    assign bus.count_o    = count_q;

    // Protocol checks: the two consumers must not both retire the head, and occupancy stays bounded.
    a_single_pop : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(bus.pop_ld_i && bus.pop_st_i)
    ) else $error("lsu_req_queue: pop_ld_i and pop_st_i asserted together");

    a_push_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        !(bus.lsu_req_valid_i && !ready && !bus.flush_i)
    ) else $warning("lsu_req_queue: request dropped while queue full");

    a_count_bound : assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        count_q <= DEPTH_C
    ) else $error("lsu_req_queue: count exceeds DEPTH");

endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed self-checking bench for lsu_req_queue (DEPTH=2), covering both bypass builds.

module tb_lsu_req_queue;
    import lsu_req_queue_pkg::*;

    localparam int DEPTH = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    int checks = 0;
    int errors = 0;

    lsu_req_queue_if #(.DEPTH(DEPTH)) bus ();

    lsu_req_queue #(.DEPTH(DEPTH)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;

`ifdef LSU_REQ_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    function automatic lsu_ctrl_t make_req(input logic [2:0] tid);
        lsu_ctrl_t r;
        r           = '0;
        r.vaddr     = 32'h8000_0000 | {26'd0, tid, 3'b000};
        r.data      = {8{1'b0, tid}};
        r.be        = 4'hF ^ {1'b0, tid};
        r.operation = {1'b1, tid};
        r.trans_id  = tid;
        return r;
    endfunction

    function automatic lsu_ctrl_t head_of(input logic [2:0] tid);
        lsu_ctrl_t r;
        r       = make_req(tid);
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic drive(input logic valid, input logic [2:0] tid,
                         input logic pld, input logic pst, input logic flush);
        bus.lsu_req_valid_i = valid;
        bus.lsu_req_i       = make_req(tid);
        bus.pop_ld_i        = pld;
        bus.pop_st_i        = pst;
        bus.flush_i         = flush;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    task automatic test_reset();
        if (bus.ready_o !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_ready actual=%b required=1", bus.ready_o);
        end
        checks++;
        if (bus.empty_o !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_empty actual=%b required=1", bus.empty_o);
        end
        checks++;
        if (bus.count_o !== 2'd0) begin
            errors++; $display("[TB] FAIL reset_count actual=%0d required=0", bus.count_o);
        end
        checks++;
        if (bus.lsu_ctrl_o !== lsu_ctrl_t'('0)) begin
            errors++; $display("[TB] FAIL reset_head actual=%h required=0", bus.lsu_ctrl_o);
        end
        checks++;
    endtask

    task automatic test_latency();
        lsu_ctrl_t exp_now;
        exp_now = BYPASS ? head_of(3'd3) : lsu_ctrl_t'('0);
        drive(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        #1;
        if (bus.lsu_ctrl_o !== exp_now) begin
            errors++; $display("[TB] FAIL latency_cycle_n actual=%h required=%h", bus.lsu_ctrl_o, exp_now);
        end
        checks++;
        step();
        if (bus.lsu_ctrl_o !== head_of(3'd3)) begin
            errors++; $display("[TB] FAIL latency_cycle_n1 actual=%h required=%h", bus.lsu_ctrl_o, head_of(3'd3));
        end
        checks++;
        if (bus.count_o !== 2'd1) begin
            errors++; $display("[TB] FAIL latency_count actual=%0d required=1", bus.count_o);
        end
        checks++;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        if (bus.empty_o !== 1'b1) begin
            errors++; $display("[TB] FAIL latency_drain actual=%b required=1", bus.empty_o);
        end
        checks++;
    endtask

    task automatic test_full();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step();
        if (bus.count_o !== 2'd2 || bus.ready_o !== 1'b0) begin
            errors++; $display("[TB] FAIL full_state actual=count %0d ready %b required=count 2 ready 0", bus.count_o, bus.ready_o);
        end
        checks++;
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step();
        if (bus.count_o !== 2'd2 || bus.lsu_ctrl_o !== head_of(3'd1)) begin
            errors++; $display("[TB] FAIL full_refuse actual=count %0d head %h required=count 2 head %h", bus.count_o, bus.lsu_ctrl_o, head_of(3'd1));
        end
        checks++;
        drive(1'b1, 3'd5, 1'b1, 1'b0, 1'b0);
        #1;
        if (bus.ready_o !== 1'b0) begin
            errors++; $display("[TB] FAIL full_pop_ready_same actual=%b required=0", bus.ready_o);
        end
        checks++;
        step();
        if (bus.count_o !== 2'd1 || bus.ready_o !== 1'b1 || bus.lsu_ctrl_o !== head_of(3'd2)) begin
            errors++; $display("[TB] FAIL full_pop_next actual=count %0d ready %b head %h required=count 1 ready 1 head %h", bus.count_o, bus.ready_o, bus.lsu_ctrl_o, head_of(3'd2));
        end
        checks++;
        drive(1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
        if (bus.lsu_ctrl_o !== head_of(3'd6) || bus.count_o !== 2'd1) begin
            errors++; $display("[TB] FAIL full_order actual=count %0d head %h required=count 1 head %h", bus.count_o, bus.lsu_ctrl_o, head_of(3'd6));
        end
        checks++;
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_back_to_back();
        lsu_ctrl_t exp_head;
        logic [1:0] exp_count;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'(i), i[0], ~i[0], 1'b0);
            #1;
            if (BYPASS) begin
                exp_head  = head_of(3'(i));
                exp_count = 2'd0;
            end else begin
                exp_head  = (i == 0) ? lsu_ctrl_t'('0) : head_of(3'(i - 1));
                exp_count = (i == 0) ? 2'd0 : 2'd1;
            end
            if (bus.lsu_ctrl_o !== exp_head) begin
                errors++; $display("[TB] FAIL stream_head_%0d actual=%h required=%h", i, bus.lsu_ctrl_o, exp_head);
            end
            checks++;
            if (bus.count_o !== exp_count) begin
                errors++; $display("[TB] FAIL stream_count_%0d actual=%0d required=%0d", i, bus.count_o, exp_count);
            end
            checks++;
            @(posedge clk_i);
            #1;
        end
        drive(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        #1;
        exp_head = BYPASS ? lsu_ctrl_t'('0) : head_of(3'd1);
        if (bus.lsu_ctrl_o !== exp_head) begin
            errors++; $display("[TB] FAIL stream_tail actual=%h required=%h", bus.lsu_ctrl_o, exp_head);
        end
        checks++;
        step();
        if (bus.empty_o !== 1'b1 || bus.count_o !== 2'd0) begin
            errors++; $display("[TB] FAIL stream_drained actual=empty %b count %0d required=empty 1 count 0", bus.empty_o, bus.count_o);
        end
        checks++;
    endtask

    task automatic test_flush();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
        step();
        if (bus.count_o !== 2'd0 || bus.lsu_ctrl_o.valid !== 1'b0 || bus.ready_o !== 1'b1 || bus.empty_o !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_state actual=count %0d valid %b ready %b empty %b required=count 0 valid 0 ready 1 empty 1", bus.count_o, bus.lsu_ctrl_o.valid, bus.ready_o, bus.empty_o);
        end
        checks++;
    endtask

    task automatic test_bypass_pop();
        lsu_ctrl_t exp_head;
        drive(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
        #1;
        exp_head = BYPASS ? head_of(3'd7) : lsu_ctrl_t'('0);
        if (bus.lsu_ctrl_o !== exp_head) begin
            errors++; $display("[TB] FAIL bypass_pop_same actual=%h required=%h", bus.lsu_ctrl_o, exp_head);
        end
        checks++;
        step();
        exp_head = BYPASS ? lsu_ctrl_t'('0) : head_of(3'd7);
        if (bus.count_o !== (BYPASS ? 2'd0 : 2'd1) || bus.lsu_ctrl_o !== exp_head) begin
            errors++; $display("[TB] FAIL bypass_pop_next actual=count %0d head %h required=count %0d head %h", bus.count_o, bus.lsu_ctrl_o, BYPASS ? 0 : 1, exp_head);
        end
        checks++;
        drive(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step();
        #2;
        rst_ni = 1'b0;
        #1;
        if (bus.count_o !== 2'd0 || bus.ready_o !== 1'b1 || bus.empty_o !== 1'b1 || bus.lsu_ctrl_o !== lsu_ctrl_t'('0)) begin
            errors++; $display("[TB] FAIL async_reset actual=count %0d ready %b empty %b head %h required=count 0 ready 1 empty 1 head 0", bus.count_o, bus.ready_o, bus.empty_o, bus.lsu_ctrl_o);
        end
        checks++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        drive(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step();
        if (bus.lsu_ctrl_o !== head_of(3'd5) || bus.count_o !== 2'd1) begin
            errors++; $display("[TB] FAIL reset_first_push actual=count %0d head %h required=count 1 head %h", bus.count_o, bus.lsu_ctrl_o, head_of(3'd5));
        end
        checks++;
    endtask

    initial begin
        drive(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        #12;
        test_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #2;
        test_reset();
        test_latency();
        test_full();
        test_back_to_back();
        test_flush();
        test_bypass_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
